// File: rtl/nonce_result_scanner.sv
// -----------------------------------------------------------------------------
// nonce_result_scanner
//
// Purpose:
//   Runs after the hash engine has finished. It reads NUM_NONCES consecutive
//   32-bit hash words from a single-port memory, starting at hash_addr. It then
//   reports two results:
//     - the first nonce whose hash is strictly below the difficulty target;
//     - the minimum hash word seen, and the lowest index that holds it.
//
// Optional feature (compile-time macro SCAN_WRITEBACK_EN):
//   When the macro is defined, a single WB cycle follows the scan. It writes a
//   summary word to base + NUM_NONCES, with this layout:
//     bit 31     : found
//     bits 15:8  : min_idx
//     bits 7:0   : nonce_idx
//   When the macro is undefined, the WB state does not exist, and mem_we and
//   mem_write_data are tied to 0.
//
// Ports:
//   clk            in   single clock
//   reset_n        in   asynchronous, active-low reset
//   start          in   begins a scan; only looked at while idle
//   hash_addr[15:0] in  base address of the hash word for nonce 0
//   target[31:0]   in   a hash qualifies when hash < target (unsigned)
//   done           out  high while idle
//   found          out  at least one qualifying hash in the last scan
//   nonce_idx      out  lowest qualifying nonce index (0 when !found)
//   min_hash[31:0] out  unsigned minimum hash of the last scan
//   min_idx        out  lowest index holding min_hash
//   mem_clk        out  copy of clk for the memory
//   mem_we         out  memory write enable
//   mem_addr[15:0] out  memory address
//   mem_write_data out  memory write data
//   mem_read_data  in   memory read data (one cycle after the address)
//
// Handshake:
//   start is a level that is sampled on a rising edge while done=1. The scan
//   starts on that edge. done falls in the next cycle and rises again once the
//   results are final. While done=0, start is ignored. Results hold until the
//   next accepted start.
//
// Debug:
//   The FSM state is available as the internal signal `state`.
// -----------------------------------------------------------------------------
module nonce_result_scanner #(
  parameter int NUM_NONCES = 16,
  parameter int IDX_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      hash_addr,
  input  logic [31:0]      target,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] nonce_idx,
  output logic [31:0]      min_hash,
  output logic [IDX_W-1:0] min_idx,
  output logic             mem_clk,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  // Wide enough to count 0..255 plus headroom.
  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NONCES - 1);

`ifdef SCAN_WRITEBACK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_WB    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic [15:0]      base_q;
  logic [31:0]      target_q;
  logic [CNT_W-1:0] rd_cnt;
  // The valid pipe marks which cycle's mem_read_data belongs to an issued
  // read, and it carries that read's index to the compare stage.
  logic             vld_q;
  logic [IDX_W-1:0] vld_idx_q;

  assign mem_clk = clk;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and memory-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    done           = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'h0000;
    mem_write_data = 32'h0000_0000;
    case (state)
      S_IDLE: begin
        done = 1'b1;
        if (start) state_nxt = S_READ;
      end
      S_READ: begin
        // Addresses wrap modulo 2^16.
        mem_addr = base_q + 16'(rd_cnt);
        if (rd_cnt == LAST_CNT) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef SCAN_WRITEBACK_EN
        state_nxt = S_WB;
`else
        state_nxt = S_IDLE;
`endif
      end
`ifdef SCAN_WRITEBACK_EN
      S_WB: begin
        mem_we         = 1'b1;
        mem_addr       = base_q + 16'(NUM_NONCES);
        mem_write_data = {found, 15'h0000, 8'(min_idx), 8'(nonce_idx)};
        state_nxt      = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: latch the request, count the reads, and compare the returns
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q    <= 16'h0000;
      target_q  <= 32'h0000_0000;
      rd_cnt    <= '0;
      vld_q     <= 1'b0;
      vld_idx_q <= '0;
      found     <= 1'b0;
      nonce_idx <= '0;
      min_hash  <= 32'hFFFF_FFFF;
      min_idx   <= '0;
    end else begin
      vld_q <= 1'b0;

      if (state == S_IDLE && start) begin
        base_q    <= hash_addr;
        target_q  <= target;
        rd_cnt    <= '0;
        found     <= 1'b0;
        nonce_idx <= '0;
        min_hash  <= 32'hFFFF_FFFF;
        min_idx   <= '0;
      end

      if (state == S_READ) begin
        rd_cnt    <= rd_cnt + 1'b1;
        vld_q     <= 1'b1;
        vld_idx_q <= IDX_W'(rd_cnt);
      end

      // vld_q is only ever set in READ or DRAIN, so this compare never
      // overlaps the clear that happens on start.
      // The comparisons are strict, so equal values keep the earlier index,
      // and a hash equal to the target does not qualify.
      if (vld_q) begin
        if (!found && (mem_read_data < target_q)) begin
          found     <= 1'b1;
          nonce_idx <= vld_idx_q;
        end
        if (mem_read_data < min_hash) begin
          min_hash <= mem_read_data;
          min_idx  <= vld_idx_q;
        end
      end
    end
  end

endmodule
